// File: rtl/multicycle_ctrl.sv
// Control FSM for a shared-ALU, shared-memory multi-cycle RV32I datapath.
// Memory waits are bounded by a watchdog; illegal opcodes and timeouts park in a sticky trap.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUsrcA,
  output logic [1:0]       ALUsrcB,
  output logic [1:0]       ALUop,
  output logic             PCsrc,
  output logic [3:0]       state,
  output logic             retire,
  output logic             trap,
  output logic             trap_cause,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StExecR   = 4'd3,
    StExecI   = 4'd4,
    StMemAddr = 4'd5,
    StMemRd   = 4'd6,
    StMemWb   = 4'd7,
    StMemWr   = 4'd8,
    StBranch  = 4'd9,
    StAluWb   = 4'd10,
    StTrap    = 4'd11
  } state_e;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_src;
  } ctrl_t;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [7:0]       wait_q, wait_d;
  logic             cause_q, cause_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             instr_end;
  logic             timed_out;
  logic             wait_state;
  logic             fetch_done;
  logic             br_taken;

  // State-only controls, looked up for the state being entered so they come out of a register.
  function automatic ctrl_t decode_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      StDecode:  c.alu_src_b = 2'b10;
      StExecR: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      StExecI, StMemAddr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      StMemRd: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      StMemWb: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      StMemWr: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      StBranch: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 1'b1;
      end
      StAluWb:   c.reg_write = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  assign wait_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    instr_end = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      StIdle:    if (run) state_d = StFetch;
      StFetch: begin
        if (mem_ready)             state_d   = StDecode;
        else if (wait_q == WaitLast) timed_out = 1'b1;
      end
      StDecode: begin
        case (opcode)
          OpR:              state_d = StExecR;
          OpImm:            state_d = StExecI;
          OpLoad, OpStore:  state_d = StMemAddr;
          OpBranch:         state_d = StBranch;
          default: begin
            state_d = StTrap;
            cause_d = 1'b0;
          end
        endcase
      end
      StExecR, StExecI: state_d = StAluWb;
      StMemAddr: state_d = (opcode == OpStore) ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ready)             state_d   = StMemWb;
        else if (wait_q == WaitLast) timed_out = 1'b1;
      end
      StMemWr: begin
        if (mem_ready)             instr_end = 1'b1;
        else if (wait_q == WaitLast) timed_out = 1'b1;
      end
      StAluWb, StMemWb, StBranch: instr_end = 1'b1;
      StTrap:    state_d = StTrap;
      default:   state_d = StIdle;
    endcase
    if (timed_out) begin
      state_d = StTrap;
      cause_d = 1'b1;
    end
    if (instr_end) state_d = run ? StFetch : StIdle;
  end

  always_comb begin
    wait_d  = wait_q;
    count_d = count_q;
    // Any state change restarts the watchdog, so each wait state begins from zero.
    if (state_d != state_q)          wait_d = '0;
    else if (wait_state && !mem_ready) wait_d = wait_q + 8'd1;
    if (instr_end) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
      wait_q  <= '0;
      cause_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
      wait_q  <= wait_d;
      cause_q <= cause_d;
      count_q <= count_d;
    end
  end

  assign fetch_done = (state_q == StFetch) && mem_ready;
  assign br_taken   = (funct3 == 3'b000) ? zero :
                      (funct3 == 3'b001) ? ~zero : 1'b0;

  assign PCWrite     = fetch_done || ((state_q == StBranch) && br_taken);
  assign IRWrite     = fetch_done;
  assign IorD        = ctrl_q.iord;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign RegWrite    = ctrl_q.reg_write;
  assign ALUsrcA     = ctrl_q.alu_src_a;
  assign ALUsrcB     = ctrl_q.alu_src_b;
  assign ALUop       = ctrl_q.alu_op;
  assign PCsrc       = ctrl_q.pc_src;
  assign state       = state_q;
  assign retire      = instr_end;
  assign trap        = (state_q == StTrap);
  assign trap_cause  = cause_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected per-cycle state
// sequence from instruction class and memory latencies, then replayed against the DUT.
module tb_multicycle_ctrl;

  localparam int Timeout = 16;
  localparam int CntW    = 4;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3, S_EXEC_I = 4;
  localparam int S_MEM_ADDR = 5, S_MEM_RD = 6, S_MEM_WB = 7, S_MEM_WR = 8, S_BRANCH = 9;
  localparam int S_ALU_WB = 10, S_TRAP = 11;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_ILL = 5;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011;

  logic            clk = 1'b0;
  logic            rst_n, run, zero, mem_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite, ALUsrcA;
  logic [1:0]      ALUsrcB, ALUop;
  logic            PCsrc, retire, trap, trap_cause;
  logic [3:0]      state;
  logic [CntW-1:0] instr_count;
  logic [12:0]     got_ctrl;

  multicycle_ctrl #(
    .TIMEOUT(Timeout),
    .CNT_W  (CntW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .funct3     (funct3),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ALUsrcA    (ALUsrcA),
    .ALUsrcB    (ALUsrcB),
    .ALUop      (ALUop),
    .PCsrc      (PCsrc),
    .state      (state),
    .retire     (retire),
    .trap       (trap),
    .trap_cause (trap_cause),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign got_ctrl = {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite, ALUsrcA,
                     ALUsrcB, ALUop, PCsrc};

  int total, bad;

  // Reference model state and the per-cycle plan for the current instruction.
  logic [CntW-1:0] m_count;
  bit              m_idle;
  bit              exp_cause;
  int              q_st[$];
  bit              q_rdy[$];
  bit              q_run[$];
  bit              q_end[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic logic [12:0] exp_ctrl(input int st, input bit rdy, input bit z,
                                           input logic [2:0] f3);
    logic taken;
    taken = (f3 == 3'b000) ? z : (f3 == 3'b001) ? ~z : 1'b0;
    case (st)
      S_FETCH:              return {rdy, rdy, 1'b0, 1'b1, 3'b000, 1'b0, 2'b01, 2'b00, 1'b0};
      S_DECODE:             return {7'b0, 1'b0, 2'b10, 2'b00, 1'b0};
      S_EXEC_R:             return {7'b0, 1'b1, 2'b00, 2'b10, 1'b0};
      S_EXEC_I, S_MEM_ADDR: return {7'b0, 1'b1, 2'b10, 2'b00, 1'b0};
      S_MEM_RD:             return {2'b00, 1'b1, 1'b1, 3'b000, 6'b0};
      S_MEM_WB:             return {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b0};
      S_MEM_WR:             return {2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0};
      S_BRANCH:             return {taken, 6'b0, 1'b1, 2'b00, 2'b01, 1'b1};
      S_ALU_WB:             return {6'b0, 1'b1, 6'b0};
      default:              return '0;
    endcase
  endfunction

  function automatic logic [6:0] rand_illegal();
    logic [6:0] op;
    do op = 7'($urandom); while (op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR});
    return op;
  endfunction

  function automatic int rand_delay();
    int r;
    r = $urandom_range(0, 15);
    if (r < 10) return 0;
    if (r < 14) return $urandom_range(1, 4);
    if (r == 14) return Timeout - 1;
    return Timeout + 3;
  endfunction

  task automatic push(input int st, input bit rdy, input bit rn, input bit e);
    q_st.push_back(st);
    q_rdy.push_back(rdy);
    q_run.push_back(rn);
    q_end.push_back(e);
  endtask

  // A memory wait lasting d stall cycles; the watchdog fires on the TIMEOUT-th unready cycle.
  task automatic wait_phase(input int st, input int d, input bit run_after, input bit ends,
                            output bit tr);
    tr = 1'b0;
    for (int k = 0; k <= d; k++) begin
      if (k == Timeout - 1 && d > k) begin
        push(st, 1'b0, rb(), 1'b0);
        tr = 1'b1;
        break;
      end
      push(st, 1'(k == d), (k == d && ends) ? run_after : rb(), 1'(k == d && ends));
    end
  endtask

  task automatic build(input int kind, input int df, input int dm, input bit run_after,
                       input int tlen, output bit tr);
    int n;
    if (m_idle) begin
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) push(S_IDLE, rb(), 1'b0, 1'b0);
      push(S_IDLE, rb(), 1'b1, 1'b0);
    end
    wait_phase(S_FETCH, df, 1'b0, 1'b0, tr);
    if (tr) exp_cause = 1'b1;
    else begin
      push(S_DECODE, rb(), rb(), 1'b0);
      case (kind)
        K_R: begin
          push(S_EXEC_R, rb(), rb(), 1'b0);
          push(S_ALU_WB, rb(), run_after, 1'b1);
        end
        K_I: begin
          push(S_EXEC_I, rb(), rb(), 1'b0);
          push(S_ALU_WB, rb(), run_after, 1'b1);
        end
        K_LD: begin
          push(S_MEM_ADDR, rb(), rb(), 1'b0);
          wait_phase(S_MEM_RD, dm, 1'b0, 1'b0, tr);
          if (tr) exp_cause = 1'b1;
          else push(S_MEM_WB, rb(), run_after, 1'b1);
        end
        K_ST: begin
          push(S_MEM_ADDR, rb(), rb(), 1'b0);
          wait_phase(S_MEM_WR, dm, run_after, 1'b1, tr);
          if (tr) exp_cause = 1'b1;
        end
        K_BR: push(S_BRANCH, rb(), run_after, 1'b1);
        default: begin
          tr        = 1'b1;
          exp_cause = 1'b0;
        end
      endcase
    end
    if (tr) for (int k = 0; k < tlen; k++) push(S_TRAP, rb(), rb(), 1'b0);
    else m_idle = !run_after;
  endtask

  // Replays the plan one cycle at a time; rst_n is pulled low during cycle abort_at.
  task automatic run_seq(input int abort_at);
    for (int i = 0; i < q_st.size(); i++) begin
      @(negedge clk);
      rst_n     = (i != abort_at);
      mem_ready = q_rdy[i];
      run       = q_run[i];
      #4;
      check("state", 64'(state), 64'(q_st[i]));
      check("ctrl", 64'(got_ctrl), 64'(exp_ctrl(q_st[i], q_rdy[i], zero, funct3)));
      check("retire", 64'(retire), 64'(q_end[i]));
      check("trap", 64'({trap, trap_cause}),
            64'({q_st[i] == S_TRAP, (q_st[i] == S_TRAP) ? exp_cause : 1'b0}));
      check("instr_count", 64'(instr_count), 64'(m_count));
      if (q_end[i]) m_count = m_count + 1'b1;
      if (i == abort_at) begin
        m_count = '0;
        m_idle  = 1'b1;
        break;
      end
    end
    q_st.delete();
    q_rdy.delete();
    q_run.delete();
    q_end.delete();
    exp_cause = 1'b0;
  endtask

  task automatic do_instr(input int kind, input logic [6:0] ill, input logic [2:0] f3,
                          input bit z, input int df, input int dm, input bit ra,
                          input int tlen, input int abort_back);
    bit tr;
    int ab;
    @(posedge clk);
    #1;
    case (kind)
      K_R:     opcode = OP_R;
      K_I:     opcode = OP_I;
      K_LD:    opcode = OP_LD;
      K_ST:    opcode = OP_ST;
      K_BR:    opcode = OP_BR;
      default: opcode = ill;
    endcase
    funct3 = f3;
    zero   = z;
    build(kind, df, dm, ra, tlen, tr);
    if (tr)                  ab = q_st.size() - 1;
    else if (abort_back > 0) ab = q_st.size() - abort_back;
    else                     ab = -1;
    run_seq(ab);
  endtask

  initial begin
    int kind;
    total     = 0;
    bad       = 0;
    m_count   = '0;
    m_idle    = 1'b1;
    exp_cause = 1'b0;
    rst_n     = 1'b0;
    run       = 1'b1;
    zero      = 1'b0;
    mem_ready = 1'b1;
    opcode    = OP_R;
    funct3    = 3'b000;

    repeat (2) @(negedge clk);
    #4;
    check("reset state", 64'(state), 64'(S_IDLE));
    check("reset ctrl", 64'(got_ctrl), 64'(0));
    check("reset retire", 64'(retire), 64'(0));
    check("reset trap", 64'({trap, trap_cause}), 64'(0));
    check("reset count", 64'(instr_count), 64'(0));

    do_instr(K_R, 7'h00, 3'b000, 1'b0, 0, 0, 1'b1, 0, 0);
    do_instr(K_LD, 7'h00, 3'b000, 1'b0, 0, 3, 1'b1, 0, 0);
    do_instr(K_BR, 7'h00, 3'b000, 1'b1, 0, 0, 1'b1, 0, 0);
    do_instr(K_BR, 7'h00, 3'b001, 1'b1, 0, 0, 1'b1, 0, 0);
    do_instr(K_ILL, 7'h7f, 3'b000, 1'b0, 0, 0, 1'b1, 20, 0);
    do_instr(K_R, 7'h00, 3'b000, 1'b0, 100, 0, 1'b1, 3, 0);
    do_instr(K_R, 7'h00, 3'b000, 1'b0, Timeout - 1, 0, 1'b1, 0, 0);
    do_instr(K_I, 7'h00, 3'b000, 1'b0, 0, 0, 1'b0, 0, 0);
    do_instr(K_ST, 7'h00, 3'b000, 1'b0, 0, 5, 1'b1, 0, 3);

    for (int n = 0; n < 160; n++) begin
      kind = $urandom_range(K_R, K_BR);
      if ($urandom_range(0, 11) == 0) kind = K_ILL;
      do_instr(kind, rand_illegal(),
               ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1)),
               rb(), rand_delay(), rand_delay(), ($urandom_range(0, 3) != 0),
               $urandom_range(1, 5), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
